// File: rtl/instr_mem_loader.sv
// Byte-stream loader that assembles little-endian instruction words into memory.
// Holds the CPU in reset until a complete image has been written.
module instr_mem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   load_len,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [N-1:0]  mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_rst
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state;
    logic [AW:0]   len;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_cnt;
    logic [23:0]   word;
    logic          len_ok;
    logic          last_word;

    assign len_ok    = (load_len != '0) && (load_len <= DEPTH_W);
    assign last_word = ({1'b0, word_idx} == len - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_rst    <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state      <= RECV;
                            len        <= load_len;
                            word_idx   <= '0;
                            byte_cnt   <= '0;
                            error      <= 1'b0;
                            cpu_rst    <= 1'b1;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        unique case (byte_cnt)
                            2'd0: word[7:0]   <= byte_data;
                            2'd1: word[15:8]  <= byte_data;
                            2'd2: word[23:16] <= byte_data;
                            2'd3: begin
                                // Final byte goes straight to the write port.
                                state      <= WRITE;
                                byte_ready <= 1'b0;
                                mem_we     <= 1'b1;
                                mem_addr   <= {{(N-AW-2){1'b0}}, word_idx, 2'b00};
                                mem_wdata  <= {byte_data, word};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= RECV;
                        word_idx   <= word_idx + 1'b1;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cpu_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule
